bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 16, address width; DW, default 16, data width; MAX_BURST, default 4, maximum owned cycles while the other port waits.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-004 req  input  2  per-port bus request; bit 0 = CPU port, bit 1 = DMA port.
REQ-005 done  input  2  per-port single-cycle release pulse from the current owner.
REQ-006 addr0, addr1  input  AW  per-port address.
REQ-007 wdata0, wdata1  input  DW  per-port write data.
REQ-008 we0, we1  input  1  per-port write enable.
REQ-009 gnt  output  2  registered one-hot grant; at most one bit high.
REQ-010 bus_addr  output  AW  shared address bus.
REQ-011 bus_wdata  output  DW  shared write-data bus.
REQ-012 bus_we  output  1  shared write enable.
REQ-013 bus_oe  output  1  drive enable for the shared data bus; high only while a port owns the bus.
REQ-014 preempt  output  1  one-cycle pulse when an owner is forcibly released.

Function
REQ-015 FSM states SHALL be IDLE, GNT0, GNT1, GAP; gnt = 01 in GNT0, 10 in GNT1, 00 otherwise.
REQ-016 IDLE/GAP: with req=00 next state SHALL be IDLE; with one bit set, grant that port; with req=11, grant the port that is not last_owner.
REQ-017 Grant latency SHALL be one cycle: req sampled high at edge k in IDLE gives gnt high after edge k.
REQ-018 last_owner SHALL update on every entry to GNT0/GNT1 to that port number.
REQ-019 In GNTx: bus_addr=addrx, bus_wdata=wdatax, bus_we=wex, bus_oe=1, all combinational from the state.
REQ-020 Outside GNTx: bus_addr=0, bus_wdata=0, bus_we=0, bus_oe=0.
REQ-021 burst_cnt SHALL clear on GNTx entry and increment each owned cycle, saturating at MAX_BURST.
REQ-022 GNTx SHALL exit to GAP when done[x]=1, req[x]=0, or (burst_cnt=MAX_BURST-1 and req of the other port=1).
REQ-023 preempt SHALL pulse on the edge that leaves GNTx on the burst condition only, not when done[x] or req[x]=0 coincides.
REQ-024 With no competing request, the owner SHALL keep the bus indefinitely; burst_cnt saturates, no preemption.
REQ-025 done bits of non-owning ports and done in IDLE/GAP SHALL be ignored.
REQ-026 GAP SHALL last exactly one cycle (bus turnaround, bus_oe=0) on every ownership release, including re-grant to the same port.
REQ-027 A port whose req stays high after release SHALL be eligible in GAP; with req=11 the other port wins by round-robin.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, gnt=00, bus_oe=0, bus_we=0, bus_addr=0, bus_wdata=0, preempt=0, burst_cnt=0, last_owner=1, irrespective of clk.
REQ-029 Reset during GNTx SHALL drop gnt and bus_oe asynchronously; after release, first arbitration favours port 0 on req=11.
REQ-030 First grant after reset deassertion SHALL occur no earlier than the first rising edge with reset=1.

Verification
REQ-031 Reset, then req=01, addr0=0x0010, we0=1 -> gnt=01 after one edge, bus_addr=0x0010, bus_we=1, bus_oe=1.
REQ-032 req=11 simultaneously from IDLE after reset -> gnt=01 first; after done[0] -> one GAP cycle with gnt=00, bus_oe=0, then gnt=10.
REQ-033 Port 0 owns, holds req with no done, port 1 requests, MAX_BURST=4 -> exactly 4 GNT0 cycles, preempt=1 on exit, GAP, then gnt=10.
REQ-034 Port 1 sole requester for 20 cycles -> gnt=10 throughout, preempt never asserts, bus_oe stays 1.
REQ-035 done[1] pulsed while port 0 owns -> no state change; port 0 keeps gnt=01.
REQ-036 reset driven low mid-GNT1 between edges -> gnt=00, bus_oe=0, bus_addr=0 without a clock edge; after release with req=11 -> gnt=01.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-port bus arbiter: round-robin on contention, burst-limited ownership with preemption,
// and a one-cycle turnaround gap on every release.
module bus_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    done,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          we0,
  input  logic          we1,
  output logic [1:0]    gnt,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_we,
  output logic          bus_oe,
  output logic          preempt
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            last_owner_q, last_owner_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            preempt_q, preempt_d;

  logic            owner;
  logic            own_req, own_done, other_req, burst_hit, owned;

  always_comb begin
    owner     = (state_q == GNT1);
    owned     = (state_q == GNT0) || (state_q == GNT1);
    own_req   = owner ? req[1]  : req[0];
    own_done  = owner ? done[1] : done[0];
    other_req = owner ? req[0]  : req[1];
    burst_hit = (burst_cnt_q == CW'(MAX_BURST - 1)) && other_req;
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    preempt_d    = 1'b0;
    gnt_d        = 2'b00;

    case (state_q)
      IDLE, GAP: begin
        case (req)
          2'b01:   state_d = GNT0;
          2'b10:   state_d = GNT1;
          2'b11:   state_d = last_owner_q ? GNT0 : GNT1;
          default: state_d = IDLE;
        endcase
      end
      GNT0, GNT1: begin
        if (own_done || !own_req || burst_hit) begin
          state_d   = GAP;
          // Only a release forced by the burst limit counts as preemption.
          preempt_d = own_req && !own_done && burst_hit;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!owned && (state_d == GNT0 || state_d == GNT1)) begin
      burst_cnt_d  = '0;
      last_owner_d = (state_d == GNT1);
    end else if (owned && state_d != GAP) begin
      if (burst_cnt_q != CW'(MAX_BURST)) burst_cnt_d = burst_cnt_q + 1'b1;
    end else if (state_d == GAP) begin
      burst_cnt_d = '0;
    end

    if (state_d == GNT0)      gnt_d = 2'b01;
    else if (state_d == GNT1) gnt_d = 2'b10;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
      preempt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      preempt_q    <= preempt_d;
    end
  end

  // Shared bus is a pure decode of the registered state, so reset clears it immediately.
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    bus_oe    = 1'b0;
    if (state_q == GNT0) begin
      bus_addr  = addr0;
      bus_wdata = wdata0;
      bus_we    = we0;
      bus_oe    = 1'b1;
    end else if (state_q == GNT1) begin
      bus_addr  = addr1;
      bus_wdata = wdata1;
      bus_we    = we1;
      bus_oe    = 1'b1;
    end
  end

  assign gnt     = gnt_q;
  assign preempt = preempt_q;

endmodule
